startup_gsr_seq: RTL and testbench

STARTUP_GSR_SEQ -- requirements
Module: startup_gsr_seq

---
 rtl/startup_pkg.sv | 47 ++++
 rtl/startup_dly_cnt.sv | 40 ++++
 rtl/startup_gsr_seq.sv | 145 ++++++++++++++
 tb/tb_startup_gsr_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/startup_pkg.sv
// startup_pkg: shared state encodings, output-vector constants and decode
// helper for the startup primitive models.
//   startup_state_e : 3-bit state encoding exposed on the STATE debug port
//   startup_out_t   : packed {gsr, gts, gwe, eos} output vector
//   startup_decode  : Moore output decode, illegal encodings map to RESET
package startup_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_GSR_HOLD = 3'd1,
        ST_GTS_REL  = 3'd2,
        ST_GWE_REL  = 3'd3,
        ST_DONE     = 3'd4,
        ST_USER_GSR = 3'd5
    } startup_state_e;

    typedef struct packed {
        logic gsr;
        logic gts;
        logic gwe;
        logic eos;
    } startup_out_t;

    localparam startup_out_t OUT_RESET    = 4'b1100;
    localparam startup_out_t OUT_GSR_HOLD = 4'b1100;
    localparam startup_out_t OUT_GTS_REL  = 4'b0100;
    localparam startup_out_t OUT_GWE_REL  = 4'b0000;
    localparam startup_out_t OUT_DONE     = 4'b0011;
    localparam startup_out_t OUT_USER_GSR = 4'b1000;

    function automatic startup_out_t startup_decode(input startup_state_e st);
        startup_out_t o;
        case (st)
            ST_RESET:    o = OUT_RESET;
            ST_GSR_HOLD: o = OUT_GSR_HOLD;
            ST_GTS_REL:  o = OUT_GTS_REL;
            ST_GWE_REL:  o = OUT_GWE_REL;
            ST_DONE:     o = OUT_DONE;
            ST_USER_GSR: o = OUT_USER_GSR;
            default:     o = OUT_RESET;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/startup_dly_cnt.sv
// startup_dly_cnt: loadable 8-bit down-counter with zero flag.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   load       : load load_val this cycle (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, holding at zero
//   zero       : count is zero
module startup_dly_cnt
    import startup_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/startup_gsr_seq.sv
// startup_gsr_seq: FPGA startup sequencer for global set/reset (GSR),
// global tristate (GTS), global write enable (GWE) and end-of-startup (EOS),
// with user-requested re-assertion of GSR after startup completes.
//   C        : clock
//   CLR_N    : asynchronous active-low reset, restarts the sequence
//   GSR_REQ  : user GSR request, optionally inverted by IS_GSR_REQ_INVERTED
//   GSR/GTS/GWE/EOS : registered Moore outputs
//   STATE    : current state encoding (debug)
module startup_gsr_seq
    import startup_pkg::*;
#(
    parameter int unsigned GSR_CYCLES          = 4,
    parameter int unsigned GTS_DELAY           = 1,
    parameter int unsigned GWE_DELAY           = 2,
    parameter logic        IS_GSR_REQ_INVERTED = 1'b0
) (
    input  logic       C,
    input  logic       CLR_N,
    input  logic       GSR_REQ,
    output logic       GSR,
    output logic       GTS,
    output logic       GWE,
    output logic       EOS,
    output logic [2:0] STATE
);

    localparam logic [CNT_W-1:0] GSR_LOAD = CNT_W'(GSR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GTS_LOAD = CNT_W'(GTS_DELAY - 1);
    localparam logic [CNT_W-1:0] GWE_LOAD = CNT_W'(GWE_DELAY - 1);

    startup_state_e   state_q, state_d;
    logic             from_user_q, from_user_d;
    startup_out_t     out_q, out_d;

    logic             req_eff;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign req_eff = GSR_REQ ^ IS_GSR_REQ_INVERTED;

    startup_dly_cnt u_dly_cnt (
        .clk      (C),
        .rst_n    (CLR_N),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register; outputs are registered from the next state so they
    // change on the same edge as STATE and never glitch.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q     <= ST_RESET;
            from_user_q <= 1'b0;
            out_q       <= OUT_RESET;
        end else begin
            state_q     <= state_d;
            from_user_q <= from_user_d;
            out_q       <= out_d;
        end
    end

    // Next-state logic. from_user marks a GWE_REL phase entered from
    // USER_GSR, the only GWE_REL phase in which a request is honoured.
    always_comb begin
        state_d      = state_q;
        from_user_d  = from_user_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d      = ST_GSR_HOLD;
                from_user_d  = 1'b0;
                cnt_load     = 1'b1;
                cnt_load_val = GSR_LOAD;
            end
            ST_GSR_HOLD: begin
                if (cnt_zero) begin
                    state_d      = ST_GTS_REL;
                    cnt_load     = 1'b1;
                    cnt_load_val = GTS_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GTS_REL: begin
                if (cnt_zero) begin
                    state_d      = ST_GWE_REL;
                    from_user_d  = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = GWE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GWE_REL: begin
                if (from_user_q && req_eff) begin
                    state_d      = ST_USER_GSR;
                    cnt_load     = 1'b1;
                    cnt_load_val = GSR_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (req_eff) begin
                    state_d      = ST_USER_GSR;
                    cnt_load     = 1'b1;
                    cnt_load_val = GSR_LOAD;
                end
            end
            ST_USER_GSR: begin
                if (cnt_zero && !req_eff) begin
                    state_d      = ST_GWE_REL;
                    from_user_d  = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = GWE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Output decode
    always_comb begin
        out_d = startup_decode(state_d);
    end

    assign GSR   = out_q.gsr;
    assign GTS   = out_q.gts;
    assign GWE   = out_q.gwe;
    assign EOS   = out_q.eos;
    assign STATE = state_q;

endmodule

// File: tb/tb_startup_gsr_seq.sv
// tb_startup_gsr_seq: three parameterisations of startup_gsr_seq run side by
// side against a duration-based reference model.
//   dut 0: defaults; dut 1: all delays 1; dut 2: 3/2/3 with inverted request
module tb_startup_gsr_seq;

    logic       clk;
    logic       clr_n;
    logic [2:0] gsr_req;
    logic [2:0] gsr, gts, gwe, eos;
    logic [2:0] st [3];

    int unsigned n_checks;
    int unsigned n_fail;

    // reference model: state number, cycles spent in state, return path flag
    int p_gsr [3] = '{4, 1, 3};
    int p_gts [3] = '{1, 1, 2};
    int p_gwe [3] = '{2, 1, 3};
    bit inv   [3] = '{1'b0, 1'b0, 1'b1};
    int m_state [3];
    int m_age   [3];
    bit m_user  [3];
    bit eff     [3];

    startup_gsr_seq u_def (
        .C(clk), .CLR_N(clr_n), .GSR_REQ(gsr_req[0]),
        .GSR(gsr[0]), .GTS(gts[0]), .GWE(gwe[0]), .EOS(eos[0]), .STATE(st[0])
    );

    startup_gsr_seq #(
        .GSR_CYCLES(1), .GTS_DELAY(1), .GWE_DELAY(1)
    ) u_min (
        .C(clk), .CLR_N(clr_n), .GSR_REQ(gsr_req[1]),
        .GSR(gsr[1]), .GTS(gts[1]), .GWE(gwe[1]), .EOS(eos[1]), .STATE(st[1])
    );

    startup_gsr_seq #(
        .GSR_CYCLES(3), .GTS_DELAY(2), .GWE_DELAY(3), .IS_GSR_REQ_INVERTED(1'b1)
    ) u_inv (
        .C(clk), .CLR_N(clr_n), .GSR_REQ(gsr_req[2]),
        .GSR(gsr[2]), .GTS(gts[2]), .GWE(gwe[2]), .EOS(eos[2]), .STATE(st[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {GSR,GTS,GWE,EOS} per state, straight from the output table
    function automatic logic [3:0] exp_out(input int s);
        case (s)
            1:       return 4'b1100;
            2:       return 4'b0100;
            3:       return 4'b0000;
            4:       return 4'b0011;
            5:       return 4'b1000;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_state[d] = 0;
            m_age[d]   = 0;
            m_user[d]  = 1'b0;
        end
    endfunction

    function automatic void enter(input int d, input int s);
        m_state[d] = s;
        m_age[d]   = 1;
    endfunction

    function automatic void model_step(input int d);
        case (m_state[d])
            0: begin m_user[d] = 1'b0; enter(d, 1); end
            1: if (m_age[d] == p_gsr[d]) enter(d, 2); else m_age[d]++;
            2: if (m_age[d] == p_gts[d]) begin m_user[d] = 1'b0; enter(d, 3); end
               else m_age[d]++;
            3: if (m_user[d] && eff[d]) enter(d, 5);
               else if (m_age[d] == p_gwe[d]) enter(d, 4);
               else m_age[d]++;
            4: if (eff[d]) enter(d, 5);
            5: if (m_age[d] >= p_gsr[d] && !eff[d]) begin m_user[d] = 1'b1; enter(d, 3); end
               else if (m_age[d] < 1000) m_age[d]++;
            default: enter(d, 0);
        endcase
    endfunction

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("state%0d", d), 8'(st[d]), 8'(m_state[d]));
            check_eq($sformatf("outs%0d", d), 8'({gsr[d], gts[d], gwe[d], eos[d]}),
                     8'(exp_out(m_state[d])));
            check_eq($sformatf("gsr_gwe%0d", d), 8'(gsr[d] & gwe[d]), 8'd0);
        end
    endtask

    task automatic drive_reqs();
        for (int d = 0; d < 3; d++) gsr_req[d] = eff[d] ^ inv[d];
    endtask

    task automatic set_all_req(input bit v);
        for (int d = 0; d < 3; d++) eff[d] = v;
        drive_reqs();
    endtask

    // one clock: model advances at the edge, DUTs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_step(d);
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        #2 clr_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("async_state%0d", d), 8'(st[d]), 8'd0);
            check_eq($sformatf("async_outs%0d", d), 8'({gsr[d], gts[d], gwe[d], eos[d]}), 8'hC);
        end
        #1 clr_n = 1'b1;
    endtask

    initial begin
        int lat [3];
        int exp_lat;
        n_checks = 0;
        n_fail   = 0;
        clr_n    = 1'b0;
        model_reset();
        set_all_req(1'b0);

        // reset state
        @(negedge clk);
        check_all();
        @(negedge clk);
        check_all();

        // release and measure CLR_N-to-EOS latency
        clr_n = 1'b1;
        lat = '{-1, -1, -1};
        for (int k = 1; k <= 16; k++) begin
            cycle();
            for (int d = 0; d < 3; d++)
                if (eos[d] && lat[d] < 0) lat[d] = k;
        end
        for (int d = 0; d < 3; d++) begin
            exp_lat = 1 + p_gsr[d] + p_gts[d] + p_gwe[d];
            check_eq($sformatf("eos_latency%0d", d), 8'(lat[d]), 8'(exp_lat));
        end

        // single-cycle request pulse in DONE
        set_all_req(1'b1);
        cycle();
        set_all_req(1'b0);
        cycles(12);

        // request held for ten cycles in DONE
        set_all_req(1'b1);
        cycles(10);
        set_all_req(1'b0);
        cycles(12);

        // abort during GTS_REL of the default instance, then full restart
        pulse_reset();
        cycles(5);
        check_eq("in_gts_rel", 8'(st[0]), 8'd2);
        pulse_reset();
        cycles(12);

        // randomised requests with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++)
                if ($urandom_range(0, 5) == 0) eff[d] = ~eff[d];
            drive_reqs();
            if ($urandom_range(0, 79) == 0) pulse_reset();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // hard stop in case the stimulus process ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
